sync_fifo_flagged: RTL and testbench
====================================

Name: sync_fifo_flagged

Overview:
Parametrised successor to the single-clock FIFO. It uses all DEPTH entries, with no sacrificed slot, via extended pointers. It adds:
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous flush

It sits between pipeline producers and consumers, for example between fetch and decode or as a load/store queue buffer. It is a drop-in for the older FIFO where head/tail/full/empty semantics are needed.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2.
DATA_WIDTH, 8, bits per entry.
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset asserted).
push  in  1  write request; data_in is written when accepted.
poll  in  1  read request; advances the head when accepted.
flush  in  1  synchronous clear of contents and error flags.
clr_err  in  1  synchronous clear of overflow and underflow.
data_in  in  DATA_WIDTH  write data.
head  out  DATA_WIDTH  oldest entry, first-word-fall-through; valid only when !empty.
tail  out  DATA_WIDTH  newest entry; valid only when !empty.
count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
overflow  out  1  sticky: a push was rejected.
underflow  out  1  sticky: a poll was rejected.

Behaviour:
- Pointers:
  - w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide. The low bits index storage.
  - empty = (w_ptr == r_ptr).
  - full = MSBs differ and the low bits are equal.
  - count = w_ptr - r_ptr, taken modulo 2^(AW+1). It is registered or derived, but must be cycle-exact with the pointers.
  - Wrap-around is natural binary rollover of both pointers.
- Reset:
  - Asserting rst low immediately clears w_ptr, r_ptr, overflow and underflow, without waiting for a clock edge.
  - Outputs while in and after reset: empty=1, full=0, count=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Storage is not reset, so head and tail are don't-care while empty.
  - Reset asserted mid-operation discards all contents.
  - Deassertion is sampled on clk; the first push is accepted on the first rising edge with rst=1.
- Priority per cycle: flush > push/poll.
  - flush=1: pointers are zeroed, and overflow and underflow are cleared. Any push and poll in the same cycle are ignored, and no error flag is set.
- Push accept rule: push && (!full || poll).
  - On accept: fifo[w_ptr] <= data_in, and w_ptr increments.
- Poll accept rule: poll && !empty.
  - On accept: r_ptr increments.
- Simultaneous push and poll:
  - Not full and not empty: both accepted; count unchanged.
  - Full: both accepted. The poll frees a slot that the push fills, so count stays at DEPTH and no overflow is flagged.
  - Empty: push accepted; poll rejected and underflow set. count becomes 1 and head shows the new word the next cycle.
- Rejection:
  - push && full && !poll: data is dropped, pointers are unchanged, and overflow <= 1.
  - poll && empty: underflow <= 1.
- Error flags:
  - overflow and underflow stay high until clr_err, flush or reset.
  - clr_err has priority over a same-cycle set, so the flag clears.
- Latency:
  - A word pushed at edge N appears on head after edge N if the FIFO was empty.
  - tail shows the word from the last accepted push starting the cycle after that push.
  - head is a combinational read of fifo[r_ptr]; tail reads fifo[w_ptr-1].
- Status outputs: full, empty, count and the almost flags are pure functions of the pointers and update on the same edge as the pointers.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=1):
1. Reset: rst=0 mid-stream with count=5 -> immediately count=0, empty=1, almost_empty=1, overflow=0; after rst=1, push 0xA5 -> next cycle head=0xA5, tail=0xA5, count=1.
2. Fill: push 0x00..0x07 -> full=1, count=8, almost_full=1 from count=6; 9th push of 0xFF -> overflow=1, count=8; drain yields head 0x00..0x07 in order, then empty=1.
3. Full push+poll: FIFO full with 0x00..0x07, push 0x10 and poll together -> count=8, overflow=0, head=0x01, tail=0x10.
4. Empty poll and simultaneous empty push+poll: poll while empty -> underflow=1; then clr_err -> underflow=0; then push 0x33 with poll while empty -> underflow=1, count=1, head=0x33.
5. Wrap-around: perform 20 interleaved push/poll cycles at occupancy 3 -> FIFO order preserved across pointer rollover; count stays 3; full never asserts.
6. Flush priority: count=4 and overflow=1, then flush with push 0x77 and poll -> count=0, empty=1, overflow=0, underflow=0; 0x77 is not stored.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO using all DEPTH slots via extended pointers, with occupancy
// count, programmable almost-full/almost-empty thresholds, sticky error flags and flush.
`timescale 1ns/1ps
module sync_fifo_flagged #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         poll,
    input  logic                         flush,
    input  logic                         clr_err,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [DATA_WIDTH-1:0]        tail,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_THR = (AW+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]           w_ptr_r;
    logic [AW:0]           r_ptr_r;
    logic [AW:0]           occ_s;
    logic [AW-1:0]         tail_idx_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_acc_s;
    logic                  poll_acc_s;
    logic                  ovf_set_s;
    logic                  udf_set_s;
    logic                  overflow_r;
    logic                  underflow_r;

    // Occupancy, status and accept/reject decisions derived from the pointers.
    always_comb begin
        occ_s      = w_ptr_r - r_ptr_r;
        empty_s    = (w_ptr_r == r_ptr_r);
        full_s     = (w_ptr_r[AW] != r_ptr_r[AW]) && (w_ptr_r[AW-1:0] == r_ptr_r[AW-1:0]);
        // A full FIFO still accepts a push when a poll frees a slot in the same cycle.
        push_acc_s = push && (!full_s || poll) && !flush;
        poll_acc_s = poll && !empty_s && !flush;
        ovf_set_s  = push && full_s && !poll && !flush;
        udf_set_s  = poll && empty_s && !flush;
        tail_idx_s = w_ptr_r[AW-1:0] - AW'(1);
    end

    // Read/write pointers: async clear on reset, synchronous clear on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_r <= '0;
            r_ptr_r <= '0;
        end else if (flush) begin
            w_ptr_r <= '0;
            r_ptr_r <= '0;
        end else begin
            if (push_acc_s) begin
                w_ptr_r <= w_ptr_r + (AW+1)'(1);
            end
            if (poll_acc_s) begin
                r_ptr_r <= r_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush || clr_err) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | ovf_set_s;
            underflow_r <= underflow_r | udf_set_s;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[w_ptr_r[AW-1:0]] <= data_in;
        end
    end

    assign head         = mem_r[r_ptr_r[AW-1:0]];
    assign tail         = mem_r[tail_idx_s];
    assign count        = CW'(occ_s);
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (occ_s >= AF_THR);
    assign almost_empty = (occ_s <= AE_THR);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Scoreboard bench for sync_fifo_flagged: a queue-based reference model predicts
// each cycle's outputs, and a monitor compares them after every clock edge.
`timescale 1ns/1ps
module tb_sync_fifo_flagged;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          poll = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    always #5 clk = ~clk;

    sync_fifo_flagged #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .push(push), .poll(poll), .flush(flush), .clr_err(clr_err),
        .data_in(data_in), .head(head), .tail(tail), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct {
        logic [CW-1:0] count;
        logic          full, empty, af, ae, ovf, udf;
        logic [DW-1:0] head, tail;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t snap();
        exp_t e;
        e.count = CW'(mq.size());
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= AF);
        e.ae    = (mq.size() <= AE);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.head  = (mq.size() != 0) ? mq[0] : '0;
        e.tail  = (mq.size() != 0) ? mq[mq.size()-1] : '0;
        return e;
    endfunction

    // One clock cycle of stimulus plus the model's prediction for it.
    task automatic step(input logic p, input logic q, input logic f, input logic c, input logic [DW-1:0] d);
        logic was_full, was_empty, do_pop, do_push;
        @(negedge clk);
        push = p; poll = q; flush = f; clr_err = c; data_in = d;
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            do_pop    = q && !was_empty;
            do_push   = p && (!was_full || q);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                if (p && !do_push) m_ovf = 1'b1;
                if (q && !do_pop)  m_udf = 1'b1;
            end
        end
        exp_q.push_back(snap());
        @(posedge clk);
        #2;
        push = 1'b0; poll = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_almost_empty"}, almost_empty, 1);
        chk({tag, "_almost_full"}, almost_full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_underflow"}, underflow, 0);
    endtask

    // Monitor: after each edge, compare DUT outputs against the next prediction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_count", count, mon_e.count);
            chk("sb_full", full, mon_e.full);
            chk("sb_empty", empty, mon_e.empty);
            chk("sb_almost_full", almost_full, mon_e.af);
            chk("sb_almost_empty", almost_empty, mon_e.ae);
            chk("sb_overflow", overflow, mon_e.ovf);
            chk("sb_underflow", underflow, mon_e.udf);
            if (!mon_e.empty) begin
                chk("sb_head", head, mon_e.head);
                chk("sb_tail", tail, mon_e.tail);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pr, qr;
        #3;
        check_reset_state("power_on");
        #10 rst = 1'b1;

        // 1. Reset mid-stream with five entries, then first push afterwards.
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
        chk("pre_reset_count", count, 5);
        #1 rst = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
        #1 check_reset_state("mid_reset");
        #10 rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
        chk("post_reset_head", head, 8'hA5);
        chk("post_reset_tail", tail, 8'hA5);
        chk("post_reset_count", count, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // 2. Fill, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
            if (i == 4) chk("fill_af_at5", almost_full, 0);
            if (i == 5) chk("fill_af_at6", almost_full, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 8);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", head, i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        chk("drain_empty", empty, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        // 3. Push and poll together while full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'(i));
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h10);
        chk("fullpp_count", count, 8);
        chk("fullpp_overflow", overflow, 0);
        chk("fullpp_head", head, 8'h01);
        chk("fullpp_tail", tail, 8'h10);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // 4. Underflow, clear, and push+poll on empty.
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("udf_set", underflow, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf_clr", underflow, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
        chk("emptypp_udf", underflow, 1);
        chk("emptypp_count", count, 1);
        chk("emptypp_head", head, 8'h33);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // 5. Pointer wrap at steady occupancy of three.
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, DW'($urandom));
            chk("wrap_count", count, 3);
            chk("wrap_full", full, 0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        // 6. Flush beats a same-cycle push and poll.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
        step(1'b1, 1'b0, 1'b0, 1'b0, DW'($urandom));
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("preflush_count", count, 4);
        chk("preflush_ovf", overflow, 1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovf", overflow, 0);
        chk("flush_udf", underflow, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
        chk("postflush_head", head, 8'h12);
        chk("postflush_count", count, 1);

        // Randomised traffic, alternating fill-biased and drain-biased phases.
        for (int i = 0; i < 300; i++) begin
            pr = ((i / 50) % 2 == 0) ? 70 : 30;
            qr = 100 - pr;
            step(($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < qr),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4), DW'($urandom));
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
